// File: rtl/dest_reg_pipe.sv
// dest_reg_pipe: picks the write destination (rt/rd/link/none) and tracks it through an
// NSTAGES-deep stall/flush pipeline, reporting per-stage source hits and load-use hazards.
module dest_reg_pipe #(
    parameter int NBITS   = 5,
    parameter int NSTAGES = 3,
    parameter int RA_ADDR = 31
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_valid,
    input  logic [1:0]         i_RegDst,
    input  logic               i_reg_write,
    input  logic               i_mem_read,
    input  logic [NBITS-1:0]   i_reg_rt,
    input  logic [NBITS-1:0]   i_reg_rd,
    input  logic [NBITS-1:0]   i_src_rs,
    input  logic [NBITS-1:0]   i_src_rt,
    input  logic               i_stall,
    input  logic               i_flush,
    output logic [NBITS-1:0]   o_registro,
    output logic [NSTAGES-1:0] o_rs_hit,
    output logic [NSTAGES-1:0] o_rt_hit,
    output logic               o_load_use,
    output logic               o_wb_valid,
    output logic [NBITS-1:0]   o_wb_reg
);
    localparam logic [NBITS-1:0] RA = NBITS'(RA_ADDR);

    logic [NSTAGES-1:0]            valid_q, valid_d, load_q, load_d;
    logic [NSTAGES-1:0][NBITS-1:0] reg_q, reg_d;
    logic                          entry_v;
    logic [NBITS-1:0]              entry_reg;

    assign o_registro = i_RegDst == 2'b00 ? i_reg_rt :
                        i_RegDst == 2'b01 ? i_reg_rd :
                        i_RegDst == 2'b10 ? RA : '0;
    // register 0 is never tracked, so a zero destination is not a write
    assign entry_v   = i_valid & i_reg_write & (i_RegDst != 2'b11) & (|o_registro) & ~i_flush;
    assign entry_reg = entry_v ? o_registro : '0;

    always_comb begin
        valid_d = valid_q;
        reg_d   = reg_q;
        load_d  = load_q;
        if (!i_stall) begin
            valid_d = {valid_q[NSTAGES-2:0], entry_v};
            reg_d   = {reg_q[NSTAGES-2:0], entry_reg};
            load_d  = {load_q[NSTAGES-2:0], entry_v & i_mem_read};
        end else if (i_flush) begin
            valid_d[0] = 1'b0;
            reg_d[0]   = '0;
            load_d[0]  = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            valid_q <= '0;
            reg_q   <= '0;
            load_q  <= '0;
        end else begin
            valid_q <= valid_d;
            reg_q   <= reg_d;
            load_q  <= load_d;
        end
    end

    for (genvar g = 0; g < NSTAGES; g++) begin : g_hit
        assign o_rs_hit[g] = valid_q[g] & (reg_q[g] == i_src_rs) & (|i_src_rs);
        assign o_rt_hit[g] = valid_q[g] & (reg_q[g] == i_src_rt) & (|i_src_rt);
    end

    assign o_load_use = load_q[0] & (o_rs_hit[0] | o_rt_hit[0]);
    assign o_wb_valid = valid_q[NSTAGES-1];
    assign o_wb_reg   = reg_q[NSTAGES-1];
endmodule

// File: tb/tb_dest_reg_pipe.sv
// tb_dest_reg_pipe: directed stimulus; write-back stream checked by a scoreboard monitor.
module tb_dest_reg_pipe;
    logic       i_clk = 1'b0, i_reset = 1'b1, i_valid = 1'b0, i_reg_write = 1'b0, i_mem_read = 1'b0;
    logic       i_stall = 1'b0, i_flush = 1'b0;
    logic [1:0] i_RegDst = 2'b11;
    logic [4:0] i_reg_rt = '0, i_reg_rd = '0, i_src_rs = '0, i_src_rt = '0;
    logic [4:0] o_registro, o_wb_reg;
    logic [2:0] o_rs_hit, o_rt_hit;
    logic       o_load_use, o_wb_valid;

    typedef struct {
        logic [4:0] r;
        int         t;
    } exp_t;
    exp_t exp_q[$];
    int checks = 0, failures = 0, cyc = 0;
    bit done = 1'b0;

    dest_reg_pipe #(.NBITS(5), .NSTAGES(3), .RA_ADDR(31)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .i_RegDst(i_RegDst),
        .i_reg_write(i_reg_write), .i_mem_read(i_mem_read), .i_reg_rt(i_reg_rt),
        .i_reg_rd(i_reg_rd), .i_src_rs(i_src_rs), .i_src_rt(i_src_rt), .i_stall(i_stall),
        .i_flush(i_flush), .o_registro(o_registro), .o_rs_hit(o_rs_hit), .o_rt_hit(o_rt_hit),
        .o_load_use(o_load_use), .o_wb_valid(o_wb_valid), .o_wb_reg(o_wb_reg)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive(logic v, logic we, logic [1:0] dst, logic [4:0] rt, logic [4:0] rd,
                         logic ld, logic st, logic fl);
        i_valid = v; i_reg_write = we; i_RegDst = dst; i_reg_rt = rt; i_reg_rd = rd;
        i_mem_read = ld; i_stall = st; i_flush = fl;
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle(int n);
        drive(0, 0, 2'b11, 0, 0, 0, 0, 0);
        repeat (n) step();
    endtask

    task automatic expect_wb(logic [4:0] r, int t);
        exp_t e;
        e.r = r;
        e.t = t;
        exp_q.push_back(e);
    endtask

    // monitor: every valid write-back must match the next expected entry, on its cycle
    initial begin
        exp_t e;
        while (!done) begin
            @(negedge i_clk);
            if (!i_reset && o_wb_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL wb_unexpected: got reg %0d at cycle %0d, expected none", o_wb_reg, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (o_wb_reg !== e.r || cyc != e.t) begin
                        failures++;
                        $display("FAIL wb_entry: got reg %0d at cycle %0d, expected reg %0d at cycle %0d",
                                 o_wb_reg, cyc, e.r, e.t);
                    end
                end
            end
        end
    end

    initial begin
        // reset held with a valid instruction present
        drive(1, 1, 2'b01, 8, 9, 0, 0, 0);
        i_src_rs = 9;
        i_src_rt = 9;
        repeat (2) begin
            step();
            chk("rst_wb_valid", int'(o_wb_valid), 0);
            chk("rst_wb_reg", int'(o_wb_reg), 0);
            chk("rst_rs_hit", int'(o_rs_hit), 0);
            chk("rst_rt_hit", int'(o_rt_hit), 0);
            chk("rst_load_use", int'(o_load_use), 0);
            chk("rst_registro", int'(o_registro), 9);
        end
        i_reset = 1'b0;
        expect_wb(9, cyc + 3);
        step();
        chk("post_rst_capture", int'(o_rs_hit), 3'b001);
        idle(4);

        // destination selection
        i_src_rs = 0;
        i_src_rt = 0;
        for (int d = 0; d < 4; d++) begin
            drive(0, 0, 2'(d), 8, 9, 0, 0, 0);
            #1;
            chk("sel_registro", int'(o_registro), d == 0 ? 8 : d == 1 ? 9 : d == 2 ? 31 : 0);
        end
        drive(1, 1, 2'b10, 8, 9, 0, 0, 0);
        expect_wb(31, cyc + 3);
        step();
        drive(1, 1, 2'b01, 8, 0, 0, 0, 0);
        step();
        idle(4);

        // back-to-back issue, hits walking down the pipe
        i_src_rs = 5;
        i_src_rt = 6;
        for (int k = 0; k < 3; k++) begin
            drive(1, 1, 2'b01, 0, 5'(5 + k), 0, 0, 0);
            expect_wb(5'(5 + k), cyc + 3);
            step();
            chk("pipe_rs_hit", int'(o_rs_hit), 1 << k);
            chk("pipe_rt_hit", int'(o_rt_hit), k == 0 ? 0 : 1 << (k - 1));
        end
        idle(1);
        chk("pipe_rs_hit_gone", int'(o_rs_hit), 0);
        idle(3);

        // stall for two cycles adds two cycles of latency
        i_src_rs = 10;
        drive(1, 1, 2'b01, 0, 10, 0, 0, 0);
        expect_wb(10, cyc + 5);
        step();
        drive(0, 0, 2'b11, 0, 0, 0, 1, 0);
        repeat (2) begin
            step();
            chk("stall_hold", int'(o_rs_hit), 3'b001);
        end
        idle(4);

        // flush kills the incoming instruction
        i_src_rs = 11;
        drive(1, 1, 2'b01, 0, 11, 0, 0, 1);
        step();
        chk("flush_no_entry", int'(o_rs_hit), 0);
        idle(4);

        // stall+flush clears stage 0 only, later stages hold
        i_src_rs = 12;
        i_src_rt = 13;
        drive(1, 1, 2'b01, 0, 12, 0, 0, 0);
        expect_wb(12, cyc + 4);
        step();
        drive(1, 1, 2'b01, 0, 13, 0, 0, 0);
        step();
        chk("sf_pre_rt", int'(o_rt_hit), 3'b001);
        drive(1, 1, 2'b01, 0, 14, 0, 1, 1);
        step();
        chk("sf_rs_hold", int'(o_rs_hit), 3'b010);
        chk("sf_rt_clear", int'(o_rt_hit), 0);
        idle(4);

        // load-use
        i_src_rs = 0;
        i_src_rt = 4;
        drive(1, 1, 2'b00, 4, 0, 1, 0, 0);
        expect_wb(4, cyc + 3);
        step();
        chk("lu_hit", int'(o_load_use), 1);
        i_src_rt = 0;
        #1;
        chk("lu_src_zero", int'(o_load_use), 0);
        i_src_rs = 4;
        #1;
        chk("lu_rs_hit", int'(o_load_use), 1);
        idle(4);
        i_src_rs = 0;
        i_src_rt = 4;
        drive(1, 1, 2'b00, 4, 0, 0, 0, 0);
        expect_wb(4, cyc + 3);
        step();
        chk("lu_nonload", int'(o_load_use), 0);
        chk("lu_nonload_hit", int'(o_rt_hit), 3'b001);
        idle(6);

        chk("sb_drained", exp_q.size(), 0);
        done = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got no finish by cycle %0d, expected finish", cyc);
        $fatal(1);
    end
endmodule

// File: doc/dest_reg_pipe.md
# dest_reg_pipe

Parametrised destination-register selector and write-back tracker for the MIPS datapath. Chooses the write destination (rt, rd, link register, or none) via a 2-bit RegDst code. Carries the choice down an NSTAGES-deep shift pipeline with stall and flush. Reports per-stage source-operand matches plus a load-use hazard, for use by the forwarding unit and hazard detector.

## Interface
- NBITS, 5, register-address width
- NSTAGES, 3, tracked stages after decode (≥2); stage 0 = EX, stage NSTAGES-1 = WB
- RA_ADDR, 31, link register written when RegDst = 2'b10
- i_clk  in  1  clock; all state updates on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_valid  in  1  decode-stage instruction present
- i_RegDst  in  2  00 rt, 01 rd, 10 RA_ADDR, 11 no write
- i_reg_write  in  1  instruction writes the register file
- i_mem_read  in  1  instruction is a load
- i_reg_rt, i_reg_rd  in  NBITS  instruction fields
- i_src_rs, i_src_rt  in  NBITS  source registers of the instruction now in decode
- i_stall  in  1  freeze all stages
- i_flush  in  1  kill the incoming instruction
- o_registro  out  NBITS  combinational selected destination (0 when RegDst = 11)
- o_rs_hit, o_rt_hit  out  NSTAGES  bit k: stage k holds a valid write to that source
- o_load_use  out  1  stage 0 is a valid load whose destination matches i_src_rs or i_src_rt
- o_wb_valid  out  1  last stage holds a valid write
- o_wb_reg  out  NBITS  destination of the last stage

## Operation
- Each stage k holds {valid, reg[NBITS], load}.
- Entry write: valid = i_valid & i_reg_write & (RegDst ≠ 11) & (o_registro ≠ 0) & ~i_flush. Writes to register 0 never become valid.
- Stage 0 entry: reg = o_registro, load = i_mem_read.
- Normal cycle (~i_stall): stage 0 ← entry; stage k ← stage k-1 for k ≥ 1. The last stage's contents retire.
- Stall only: every stage holds its value.
- Stall with flush: stage 0 valid is cleared; all other stages hold.
- Flush without stall: stage 0 takes a bubble (valid = 0); the other stages shift normally.
- Hit, rs: o_rs_hit[k] = valid_k & (reg_k == i_src_rs) & (i_src_rs ≠ 0). o_rt_hit is identical with i_src_rt.
- Hit outputs are combinational from the stage registers and the current inputs.
- o_load_use = load_0 & (o_rs_hit[0] | o_rt_hit[0]).
- o_wb_valid = valid of the last stage; o_wb_reg = reg of the last stage.
- Invalid stages report reg = 0 and load = 0. Those fields are cleared whenever valid is written 0.
- RegDst = 10 selects RA_ADDR regardless of i_reg_rt and i_reg_rd.

## Timing
- Reset: every stage valid/reg/load = 0. Hence o_rs_hit = o_rt_hit = 0, o_load_use = 0, o_wb_valid = 0, o_wb_reg = 0.
- o_registro still follows its inputs during reset.
- Reset has priority over stall and flush.
- Reset mid-operation discards all in-flight entries on that edge.
- Latency: an instruction accepted at edge t (no stalls) is in stage k after edge t+k.
- o_wb_valid is asserted in the cycle after edge t+NSTAGES-1, i.e. NSTAGES cycles after acceptance.
- Each stalled cycle adds one cycle of latency to every in-flight entry.
- Several stages may hit at once. The forwarding unit prioritises the lowest k; this block reports all hits.

## Test plan
- Reset: assert i_reset 2 cycles with i_valid = 1 → all outputs 0 (except o_registro); after release, first capture occurs on the next edge.
- Selection: rt = 8, rd = 9, RegDst 00/01/10/11 → o_registro = 8/9/31/0; RegDst = 01 with rd = 0 → no valid entry (o_wb_valid stays 0).
- Pipeline: issue rd = 5, 6, 7 back-to-back, NSTAGES = 3 → o_wb_reg = 5, 6, 7 on cycles 3, 4, 5 after the first acceptance; o_rs_hit walks 001 → 010 → 100 for i_src_rs = 5.
- Stall/flush: issue rd = 10, stall 2 cycles → arrival at WB delayed by 2. Flush with the rd = 11 issue → 11 never appears. Stall and flush together → stage 0 cleared, later stages unchanged.
- Load-use: load to rt = 4 in stage 0 with i_src_rt = 4 → o_load_use = 1 that cycle. The same case with i_src_rt = 0, or a non-load, → o_load_use = 0.
